brc_seq: RTL and testbench
==========================

Name: brc_seq

Overview:
Parametrised, multi-cycle successor to the single-cycle branch comparator. It latches two WIDTH-bit operands and compares them in CHUNK-bit slices, MSB slice first, one slice per clock. It produces registered less/equal flags behind valid/ready handshakes on both sides. It is the comparator for wide or low-area datapath configurations where a full-width subtract does not meet timing.

Parameters:
WIDTH, 32, operand width in bits
CHUNK, 8, slice width compared per cycle; WIDTH % CHUNK == 0 and CHUNK >= 1 are checked at elaboration
NSLICE, WIDTH/CHUNK, derived local parameter, not overridable

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  operands and mode present
o_ready  output  1  block can accept operands
i_rs1_data  input  WIDTH  operand A
i_rs2_data  input  WIDTH  operand B
i_br_un  input  1  1 = signed, 0 = unsigned (existing codebase polarity)
o_valid  output  1  results valid
i_ready  input  1  consumer accepts results
o_br_less  output  1  A < B under the selected signedness
o_br_equal  output  1  A == B

Behaviour:
- Reset (async assert, sync release): state IDLE, o_valid=0, o_br_less=0, o_br_equal=0, slice index=NSLICE-1. o_ready=1 as soon as state is IDLE.
- FSM states IDLE, CMP, DONE. o_ready = (state==IDLE). o_valid = (state==DONE).
- IDLE: on i_valid && o_ready at an edge, latch both operands and i_br_un, set idx=NSLICE-1, clear the decided flag, go to CMP.
- CMP: combinationally compare slice idx of A and B.
  - The top slice in signed mode is compared with the MSB of each operand inverted (offset binary); all other slices are compared unsigned.
  - At each edge:
    - Slice differs and no decision yet: record less=(A slice < B slice), equal=0, set the decided flag.
    - idx==0, or early exit fires: go to DONE and register the flags.
    - Otherwise: idx decrements.
  - If all slices are equal: less=0, equal=1.
- DONE: flags are held stable while i_ready=0. On i_ready=1 at an edge, go to IDLE. The first new accept can occur at the following edge.
- Latency, counted from the accept edge to o_valid high: p edges, where p is the 1-based position of the deciding slice counted from the MSB. Equal operands give NSLICE edges. With CHUNK==WIDTH the latency is 1.
- Input changes during CMP/DONE are ignored because operands are latched. i_valid is ignored while o_ready=0.
- Reset mid-CMP or mid-DONE abandons the operation: outputs return to reset values and no result is produced.

Optional Feature:
Macro BRC_EARLY_EXIT_EN.
- Defined: CMP goes to DONE at the first differing slice, giving variable latency 1..NSLICE.
- Undefined: CMP always runs all NSLICE slices. The first differing slice's result stays sticky and later slices do not overwrite it. Latency is constant NSLICE edges and the flag values are identical to the defined case.

Decomposition:
- Package brc_pkg holds:
  - typedef enum brc_state_e {BRC_IDLE, BRC_CMP, BRC_DONE}
  - default constants BRC_WIDTH=32 and BRC_CHUNK=8
- One sub-module, brc_slice_cmp: combinational CHUNK-bit compare.
  - Inputs: a, b, i_signed_top.
  - Outputs: lt, eq.
  - Instantiated once and fed by the idx-selected slice mux.

Test Plan:
1. Reset mid-CMP: accept 0x1234_5678 vs 0x1234_5679, pull i_rst_n low at the 2nd cycle -> o_valid=0, flags 0, o_ready=1 immediately; no o_valid pulse after release.
2. Unsigned early decision: rs1=0x0000_0001, rs2=0xFFFF_FFFF, br_un=0 -> less=1, equal=0. o_valid 1 edge after accept with EARLY_EXIT_EN, 4 edges without.
3. Signed vs unsigned on the top slice: rs1=0x8000_0000, rs2=0x0000_0001 -> br_un=1 gives less=1; br_un=0 gives less=0; equal=0 in both.
4. Equal operands: both 0xDEAD_BEEF, either mode -> equal=1, less=0, o_valid exactly 4 edges after accept in both builds.
5. Bottom-slice decision: rs1=0xFFFF_FF10, rs2=0xFFFF_FF20, br_un=1 -> less=1, equal=0, latency 4. Swap operands -> less=0.
6. Backpressure: result ready, hold i_ready=0 for 5 cycles while driving new i_valid with different data -> flags stable, o_ready=0, new request not accepted. Raise i_ready -> IDLE next edge; the new request is accepted the edge after.

Source files
------------

// File: rtl/brc_pkg.sv
// brc_pkg: shared state encoding and default sizes for the sequential branch comparator
package brc_pkg;

    typedef enum logic [1:0] {BRC_IDLE, BRC_CMP, BRC_DONE} brc_state_e;

    localparam int BRC_WIDTH = 32;
    localparam int BRC_CHUNK = 8;

endpackage

// File: rtl/brc_slice_cmp.sv
// brc_slice_cmp: combinational CHUNK-bit compare; the top slice flips its MSB for signed (offset binary) ordering
module brc_slice_cmp #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             i_signed_top,
    output logic             lt,
    output logic             eq
);

    logic [CHUNK-1:0] msk;

    assign msk = CHUNK'(i_signed_top) << (CHUNK - 1);
    assign lt  = (a ^ msk) < (b ^ msk);
    assign eq  = a == b;

endmodule

// File: rtl/brc_seq.sv
// brc_seq: multi-cycle slice-serial less/equal comparator, MSB slice first, valid/ready on both sides
// Build option: define BRC_EARLY_EXIT_EN to finish at the first differing slice (variable latency).
module brc_seq
    import brc_pkg::*;
#(
    parameter int WIDTH = BRC_WIDTH,
    parameter int CHUNK = BRC_CHUNK
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_rs1_data,
    input  logic [WIDTH-1:0] i_rs2_data,
    input  logic             i_br_un,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_br_less,
    output logic             o_br_equal
);

    localparam int NSLICE = WIDTH / CHUNK;
    localparam int IW     = NSLICE > 1 ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] TOP = IW'(NSLICE - 1);

    if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_cfg
        $error("brc_seq: WIDTH must be a positive multiple of CHUNK");
    end

    brc_state_e       state, next;
    logic [WIDTH-1:0] a_q, b_q;
    logic             sgn_q;
    logic [IW-1:0]    idx;
    logic             decided, less_d;
    logic             lt, eq, early, fin;

    brc_slice_cmp #(.CHUNK(CHUNK)) u_cmp (
        .a            (a_q[idx*CHUNK +: CHUNK]),
        .b            (b_q[idx*CHUNK +: CHUNK]),
        .i_signed_top (sgn_q && idx == TOP),
        .lt           (lt),
        .eq           (eq)
    );

`ifdef BRC_EARLY_EXIT_EN
    assign early = !eq;
`else
    assign early = 1'b0;
`endif
    assign fin = idx == '0 || early;

    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= BRC_IDLE;
        else          state <= next;
    end

    // next-state logic
    always_comb begin
        next = state == BRC_IDLE ? (i_valid ? BRC_CMP : BRC_IDLE)
             : state == BRC_CMP  ? (fin ? BRC_DONE : BRC_CMP)
             :                     (i_ready ? BRC_IDLE : BRC_DONE);
    end

    // handshake outputs decoded from state
    always_comb begin
        o_ready = state == BRC_IDLE;
        o_valid = state == BRC_DONE;
    end

    // operand latch, slice walk, sticky first-difference capture and result registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            sgn_q      <= 1'b0;
            idx        <= TOP;
            decided    <= 1'b0;
            less_d     <= 1'b0;
            o_br_less  <= 1'b0;
            o_br_equal <= 1'b0;
        end else if (state == BRC_IDLE && i_valid) begin
            a_q     <= i_rs1_data;
            b_q     <= i_rs2_data;
            sgn_q   <= i_br_un;
            idx     <= TOP;
            decided <= 1'b0;
        end else if (state == BRC_CMP) begin
            if (!eq && !decided) begin
                decided <= 1'b1;
                less_d  <= lt;
            end
            if (fin) begin
                o_br_less  <= decided ? less_d : (!eq && lt);
                o_br_equal <= !decided && eq;
            end else begin
                idx <= idx - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_brc_seq.sv
// tb_brc_seq: directed plus randomized checks of brc_seq against an arithmetic reference model
module tb_brc_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        br_un = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic        less;
    logic        equal;
    int          n_tests = 0;
    int          n_fail = 0;

    brc_seq dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_rs1_data (rs1),
        .i_rs2_data (rs2),
        .i_br_un    (br_un),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_br_less  (less),
        .o_br_equal (equal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        int          hi;
        d  = a ^ b;
        hi = -1;
        for (int i = 0; i < 32; i++) if (d[i]) hi = i;
`ifdef BRC_EARLY_EXIT_EN
        return hi < 0 ? 4 : 4 - hi / 8;
`else
        return 4;
`endif
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic un, input int hold);
        int   lat;
        logic el, ee;
        el = un ? ($signed(a) < $signed(b)) : (a < b);
        ee = a == b;
        @(negedge clk);
        chk("ready_idle", o_ready, 1);
        i_valid = 1'b1;
        rs1     = a;
        rs2     = b;
        br_un   = un;
        i_ready = 1'b0;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        rs1     = $urandom;
        rs2     = $urandom;
        br_un   = $urandom_range(0, 1);
        lat     = 0;
        while (!o_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, exp_lat(a, b));
        chk("less", less, el);
        chk("equal", equal, ee);
        chk("ready_busy", o_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            i_valid = 1'b1;
            rs1     = $urandom;
            rs2     = $urandom;
            @(posedge clk);
            #1;
            chk("hold_valid", o_valid, 1);
            chk("hold_ready", o_ready, 0);
            chk("hold_flags", {less, equal}, {el, ee});
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        chk("drain_valid", o_valid, 0);
        chk("drain_ready", o_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, b;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_flags", {less, equal}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 0);
        do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 0);
        do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 0);
        do_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0);
        do_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 0);
        do_op(32'hFFFF_FF10, 32'hFFFF_FF20, 1'b1, 0);
        do_op(32'hFFFF_FF20, 32'hFFFF_FF10, 1'b1, 5);
        do_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 0);

        do_op(32'h1234_5678, 32'h1234_5678, 1'b0, 0);
        @(negedge clk);
        i_valid = 1'b1;
        rs1     = 32'h1234_5678;
        rs2     = 32'h1234_5679;
        br_un   = 1'b0;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_ready", o_ready, 1);
        chk("midrst_flags", {less, equal}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("postrst_novalid", o_valid, 0);
        end

        for (int n = 0; n < 60; n++) begin
            a = $urandom;
            b = a ^ (($urandom & 32'hFF) << (8 * $urandom_range(0, 3)));
            if ($urandom_range(0, 4) == 0) b = a;
            if ($urandom_range(0, 4) == 0) b = $urandom;
            do_op(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
